// File: rtl/reg_wr_sequencer.sv
// Round-robin write sequencer for a bank of
// falling-edge-capture register blocks.
module reg_wr_sequencer #(
  parameter int NREQ         = 2,
  parameter int NUM_REGS     = 4,
  parameter int AW           = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*AW-1:0]  addr,
  input  logic [NREQ*8-1:0]   wdata,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     err,
  output logic                busy,
  output logic [NUM_REGS-1:0] reg_wr_req,
  output logic [7:0]          reg_din
);

  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (PULSE_CYCLES > HOLD_CYCLES) ?
                        PULSE_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [AW:0] NR = (AW+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic                bad_q, bad_d;
  logic [7:0]          din_q, din_d;
  logic [NUM_REGS-1:0] wr_q, wr_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     err_q, err_d;
  logic                busy_q, busy_d;

  logic                found;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       rr_nxt;
  logic [NREQ-1:0]     pick_oh;
  logic [NREQ-1:0]     gnt_oh;
  logic [AW-1:0]       pick_addr;
  logic [7:0]          pick_data;
  logic                addr_ok;
  logic [NUM_REGS-1:0] dec;

  assign pick_addr = addr[int'(pick)*AW +: AW];
  assign pick_data = wdata[int'(pick)*8 +: 8];
  assign addr_ok   = {1'b0, pick_addr} < NR;
  assign rr_nxt    = (pick == GW'(NREQ-1)) ?
                     '0 : pick + GW'(1);

  // Round-robin search starting at the pointer
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_q)+k) % NREQ]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_q)+k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      pick_oh[i] = (pick == GW'(i));
      gnt_oh[i]  = (gnt_q == GW'(i));
    end
  end

  // One-hot strobe decode of the winning address
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = (pick_addr == AW'(i));
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    bad_d   = bad_q;
    din_d   = din_q;
    wr_d    = wr_q;
    ack_d   = '0;
    err_d   = '0;
    busy_d  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          busy_d = 1'b1;
          gnt_d  = pick;
          rr_d   = rr_nxt;
          if (addr_ok) begin
            state_d = S_ASSERT;
            cnt_d   = CW'(PULSE_CYCLES-1);
            wr_d    = dec;
            din_d   = pick_data;
            bad_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            bad_d   = 1'b1;
            ack_d   = pick_oh;
            err_d   = pick_oh;
          end
        end
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYCLES-1);
          wr_d    = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ack_d   = gnt_oh;
          err_d   = bad_q ? gnt_oh : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wr_d    = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      bad_q   <= 1'b0;
      din_q   <= 8'h00;
      wr_q    <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      bad_q   <= bad_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign reg_wr_req = wr_q;
  assign reg_din    = din_q;

endmodule

// File: tb/tb_reg_wr_sequencer.sv
// Bench for reg_wr_sequencer: timeline model
// plus directed cases and a small register bank.
module tb_reg_wr_sequencer;

  localparam int N  = 2;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int P  = 2;
  localparam int H  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  ack, err;
  logic        busy;
  logic [3:0]  reg_wr_req;
  logic [7:0]  reg_din;

  logic [1:0]  req3 = '0;
  logic [3:0]  addr3 = '0;
  logic [15:0] wdata3 = '0;
  logic [1:0]  ack3, err3;
  logic        busy3;
  logic [2:0]  wr3;
  logic [7:0]  din3;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_wr_sequencer #(
    .NREQ(N), .NUM_REGS(NR), .AW(AW),
    .PULSE_CYCLES(P), .HOLD_CYCLES(H)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .busy(busy),
    .reg_wr_req(reg_wr_req), .reg_din(reg_din)
  );

  reg_wr_sequencer #(
    .NREQ(2), .NUM_REGS(3), .AW(2),
    .PULSE_CYCLES(2), .HOLD_CYCLES(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .req(req3),
    .addr(addr3), .wdata(wdata3),
    .ack(ack3), .err(err3), .busy(busy3),
    .reg_wr_req(wr3), .reg_din(din3)
  );

  // Register bank: capture din when the
  // two-stage-synchronised strobe falls
  logic [3:0] s1, s2, s3;
  logic [7:0] bank [4];
  always @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else begin
      s1 <= reg_wr_req;
      s2 <= s1;
      s3 <= s2;
      for (int i = 0; i < 4; i++)
        if (s3[i] && !s2[i]) bank[i] <= reg_din;
    end
  end

  // Model: m_t counts cycles since the grant
  int         m_t = 0;
  int         m_len = 0;
  int         m_g = 0;
  int         m_a = 0;
  int         m_ptr = 0;
  bit         m_bad = 1'b0;
  logic [7:0] m_din = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (rst) begin
      m_t   = 0;
      m_ptr = 0;
      m_din = 8'h00;
      m_bad = 1'b0;
    end else if (m_t == 0) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(m_ptr+k) % N])
          g = (m_ptr+k) % N;
      if (g >= 0) begin
        m_g   = g;
        m_a   = int'(addr[g*AW +: AW]);
        m_ptr = (g+1) % N;
        m_bad = (m_a >= NR);
        m_len = m_bad ? 1 : P+H+1;
        m_t   = 1;
        if (!m_bad) m_din = wdata[g*8 +: 8];
      end
    end else if (m_t == m_len) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  // One clock: compare outputs with the model,
  // advance the model, then land just after
  // the next rising edge.
  task automatic cyc();
    logic [31:0] e_wr, e_ack, e_err;
    @(negedge clk);
    e_wr  = (m_t >= 1 && m_t <= P && !m_bad) ?
            (32'd1 << m_a) : 32'd0;
    e_ack = (m_t != 0 && m_t == m_len) ?
            (32'd1 << m_g) : 32'd0;
    e_err = m_bad ? e_ack : 32'd0;
    chk("m_busy", 32'(busy), 32'(m_t != 0));
    chk("m_strobe", 32'(reg_wr_req), e_wr);
    chk("m_ack", 32'(ack), e_ack);
    chk("m_err", 32'(err), e_err);
    chk("m_din", 32'(reg_din), 32'(m_din));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wr_reg(input int r,
                        input logic [7:0] d);
    int n;
    req   = 2'b01;
    addr  = 4'(r);
    wdata = {8'h00, d};
    n = 0;
    while (n < 20 && ack[0] !== 1'b1) begin
      cyc();
      n++;
    end
    chk("wr_ack_seen", 32'(n < 20), 32'd1);
    req = '0;
    cyc();
    cyc();
  endtask

  logic [1:0] got [3];
  logic [7:0] gdin [3];
  int         n;
  int         lat;

  initial begin
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(reg_wr_req), 32'd0);
    chk("rst_din", 32'(reg_din), 32'h00);
    chk("rst_ack", 32'(ack), 32'd0);
    cyc();
    rst = 1'b0;

    // Single write, reg 2, data A5
    req   = 2'b01;
    addr  = 4'b0010;
    wdata = 16'h00A5;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk("t1_strobe", 32'(reg_wr_req),
          (c <= 2) ? 32'h4 : 32'h0);
      if (c <= 5)
        chk("t1_din", 32'(reg_din), 32'hA5);
      chk("t1_ack", 32'(ack),
          (c == 6) ? 32'h1 : 32'h0);
      chk("t1_err", 32'(err), 32'h0);
      chk("t1_busy", 32'(busy),
          (c <= 6) ? 32'h1 : 32'h0);
      if (c == 6) req = '0;
    end

    // Both requesters held: grants rotate
    do_reset();
    req   = 2'b11;
    addr  = {2'd3, 2'd1};
    wdata = 16'h2211;
    for (int i = 0; i < 3; i++) begin
      got[i]  = '0;
      gdin[i] = '0;
    end
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      cyc();
      if (ack != '0) begin
        got[n]  = ack;
        gdin[n] = reg_din;
        n++;
      end
    end
    req = '0;
    chk("t2_g0", 32'(got[0]), 32'h1);
    chk("t2_g1", 32'(got[1]), 32'h2);
    chk("t2_g2", 32'(got[2]), 32'h1);
    chk("t2_d0", 32'(gdin[0]), 32'h11);
    chk("t2_d1", 32'(gdin[1]), 32'h22);
    chk("t2_d2", 32'(gdin[2]), 32'h11);
    for (int c = 0; c < 8; c++) cyc();

    // Out-of-range address on a 3-register bank
    req3  = 2'b10;
    addr3 = 4'b1100;
    cyc();
    chk("t3_ack", 32'(ack3), 32'h2);
    chk("t3_err", 32'(err3), 32'h2);
    chk("t3_strobe", 32'(wr3), 32'h0);
    chk("t3_busy", 32'(busy3), 32'h1);
    req3 = '0;
    cyc();
    chk("t3_ack_end", 32'(ack3), 32'h0);
    chk("t3_err_end", 32'(err3), 32'h0);
    chk("t3_idle", 32'(busy3), 32'h0);

    // Inputs ignored after the grant
    do_reset();
    req   = 2'b01;
    addr  = 4'b0000;
    wdata = 16'h003C;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk("t4_din", 32'(reg_din), 32'h3C);
      chk("t4_strobe", 32'(reg_wr_req),
          (c <= 2) ? 32'h1 : 32'h0);
      chk("t4_ack", 32'(ack),
          (c == 6) ? 32'h1 : 32'h0);
      if (c == 2) begin
        wdata = 16'h00FF;
        req   = '0;
      end
    end

    // Reset in the middle of HOLD
    do_reset();
    req   = 2'b01;
    addr  = 4'b0001;
    wdata = 16'h0077;
    cyc();
    cyc();
    cyc();
    chk("t5_hold_strobe", 32'(reg_wr_req), 32'h0);
    chk("t5_hold_din", 32'(reg_din), 32'h77);
    rst = 1'b1;
    req = '0;
    cyc();
    chk("t5_strobe", 32'(reg_wr_req), 32'h0);
    chk("t5_din", 32'(reg_din), 32'h00);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_ack", 32'(ack), 32'h0);
    rst   = 1'b0;
    req   = 2'b11;
    addr  = 4'b1010;
    wdata = 16'h5544;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      cyc();
      if (ack != '0) begin
        lat = c;
        chk("t5_first", 32'(ack), 32'h1);
      end
    end
    chk("t5_lat", 32'(lat), 32'd6);
    req = '0;
    cyc();
    cyc();

    // Bank integration
    do_reset();
    wr_reg(0, 8'h01);
    wr_reg(1, 8'h02);
    chk("t6_r0", 32'(bank[0]), 32'h01);
    chk("t6_r1", 32'(bank[1]), 32'h02);
    chk("t6_r2_untouched", 32'(bank[2]), 32'h00);
    chk("t6_r3_untouched", 32'(bank[3]), 32'h00);
    wr_reg(2, 8'h04);
    wr_reg(3, 8'h08);
    chk("t6_r0_kept", 32'(bank[0]), 32'h01);
    chk("t6_r1_kept", 32'(bank[1]), 32'h02);
    chk("t6_r2", 32'(bank[2]), 32'h04);
    chk("t6_r3", 32'(bank[3]), 32'h08);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
